// File: rtl/counter_step_monitor_if.sv
`default_nettype none
// ============================================================================
// counter_step_monitor_if
// Sample bus and status outputs between a counter-step monitor and its user.
// Rev 1.0 - initial release
// ============================================================================
interface counter_step_monitor_if #(
    parameter int WIDTH = 128
);
    logic [WIDTH-1:0] cnt_in;
    logic             cnt_valid;
    logic             clear;
    logic             dir_out;
    logic             dir_valid;
    logic             rst_seen;
    logic             step_err;
    logic             alarm;
    logic [7:0]       err_run;
    logic [31:0]      up_events;
    logic [31:0]      down_events;

    modport master (
        output cnt_in, cnt_valid, clear,
        input  dir_out, dir_valid, rst_seen, step_err, alarm, err_run,
               up_events, down_events
    );

    modport slave (
        input  cnt_in, cnt_valid, clear,
        output dir_out, dir_valid, rst_seen, step_err, alarm, err_run,
               up_events, down_events
    );
endinterface
`default_nettype wire

// File: rtl/counter_step_monitor.sv
`default_nettype none
// ============================================================================
// counter_step_monitor
// Recovers up/down direction from successive counter samples, flags illegal
// steps and raises a sticky alarm. Event counters built only with MON_STAT_EN.
// Rev 1.0 - initial release
// ============================================================================
module counter_step_monitor #(
    parameter int WIDTH     = 128,
    parameter int ERR_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_step_monitor_if.slave mon
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_TRACK = 2'd1;
    localparam logic [1:0] ST_ALARM = 2'd2;

    localparam logic [7:0]       ERR_LIMIT_B = ERR_LIMIT[7:0];
    localparam logic [WIDTH-1:0] ONE         = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] delta;
    logic [7:0]       err_run;
    logic [7:0]       err_next;
    logic             dir_out;
    logic             dir_valid;
    logic             rst_seen;
    logic             step_err;
    logic             decode;
    logic             up_hit;
    logic             down_hit;
    logic             zero_hit;
    logic             bad_hit;
    logic             alarm;

    assign delta    = mon.cnt_in - prev;
    assign err_next = (err_run == 8'hFF) ? 8'hFF : err_run + 8'd1;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        if (mon.clear) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (mon.cnt_valid) state_nxt = ST_TRACK;
                ST_TRACK: if (bad_hit && (err_next >= ERR_LIMIT_B)) state_nxt = ST_ALARM;
                ST_ALARM: state_nxt = ST_ALARM;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // Output / control decode; classification priority is up, down, reset, illegal
    always_comb begin
        alarm    = (state == ST_ALARM);
        decode   = mon.cnt_valid && !mon.clear && (state != ST_IDLE);
        up_hit   = 1'b0;
        down_hit = 1'b0;
        zero_hit = 1'b0;
        bad_hit  = 1'b0;
        if (decode) begin
            if (delta == ONE) begin
                up_hit = 1'b1;
            end else if (delta == '1) begin
                down_hit = 1'b1;
            end else if (mon.cnt_in == '0) begin
                zero_hit = 1'b1;
            end else begin
                bad_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev      <= '0;
            err_run   <= '0;
            dir_out   <= 1'b0;
            dir_valid <= 1'b0;
            rst_seen  <= 1'b0;
            step_err  <= 1'b0;
        end else begin
            dir_valid <= up_hit | down_hit;
            rst_seen  <= zero_hit;
            step_err  <= bad_hit;
            if (up_hit) begin
                dir_out <= 1'b1;
            end else if (down_hit) begin
                dir_out <= 1'b0;
            end
            // The reference follows every accepted sample, legal or not
            if (mon.clear) begin
                prev    <= '0;
                err_run <= '0;
            end else if (mon.cnt_valid) begin
                prev <= mon.cnt_in;
                if (bad_hit) begin
                    err_run <= err_next;
                end else if (decode) begin
                    err_run <= '0;
                end
            end
        end
    end

`ifdef MON_STAT_EN
    logic [31:0] up_events;
    logic [31:0] down_events;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            up_events   <= '0;
            down_events <= '0;
        end else if (mon.clear) begin
            up_events   <= '0;
            down_events <= '0;
        end else begin
            if (up_hit && (up_events != 32'hFFFF_FFFF)) begin
                up_events <= up_events + 32'd1;
            end
            if (down_hit && (down_events != 32'hFFFF_FFFF)) begin
                down_events <= down_events + 32'd1;
            end
        end
    end

    assign mon.up_events   = up_events;
    assign mon.down_events = down_events;
`else
    assign mon.up_events   = '0;
    assign mon.down_events = '0;
`endif

    assign mon.dir_out   = dir_out;
    assign mon.dir_valid = dir_valid;
    assign mon.rst_seen  = rst_seen;
    assign mon.step_err  = step_err;
    assign mon.alarm     = alarm;
    assign mon.err_run   = err_run;

endmodule
`default_nettype wire

// File: tb/tb_counter_step_monitor.sv
`default_nettype none
// ============================================================================
// tb_counter_step_monitor
// Directed and random samples compared against a behavioural step model.
// Rev 1.0 - initial release
// ============================================================================
module tb_counter_step_monitor;
    localparam int W     = 128;
    localparam int LIMIT = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    counter_step_monitor_if #(.WIDTH(W)) bus ();

    counter_step_monitor #(.WIDTH(W), .ERR_LIMIT(LIMIT)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit           m_has_ref;
    logic [W-1:0] m_prev;
    bit           m_dir;
    bit           m_alarm;
    int           m_err;
    longint       m_up;
    longint       m_down;
    bit           e_dv, e_rs, e_se;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_has_ref = 0; m_prev = '0; m_dir = 0; m_alarm = 0;
        m_err = 0; m_up = 0; m_down = 0;
        e_dv = 0; e_rs = 0; e_se = 0;
    endtask

    task automatic model_clock(input bit v, input bit c, input logic [W-1:0] x);
        logic [W-1:0] p1, x1;
        e_dv = 0; e_rs = 0; e_se = 0;
        if (c) begin
            m_has_ref = 0; m_prev = '0; m_alarm = 0;
            m_err = 0; m_up = 0; m_down = 0;
        end else if (v) begin
            if (m_has_ref) begin
                p1 = m_prev + 1;
                x1 = x + 1;
                if (x == p1) begin
                    m_dir = 1; e_dv = 1; m_err = 0;
                    if (m_up < 64'hFFFF_FFFF) m_up++;
                end else if (x1 == m_prev) begin
                    m_dir = 0; e_dv = 1; m_err = 0;
                    if (m_down < 64'hFFFF_FFFF) m_down++;
                end else if (x == 0) begin
                    e_rs = 1; m_err = 0;
                end else begin
                    e_se = 1;
                    if (m_err < 255) m_err++;
                    if (m_err >= LIMIT) m_alarm = 1;
                end
            end
            m_has_ref = 1;
            m_prev = x;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dir_out"},   W'(bus.dir_out),   W'(m_dir));
        chk({tag, ".dir_valid"}, W'(bus.dir_valid), W'(e_dv));
        chk({tag, ".rst_seen"},  W'(bus.rst_seen),  W'(e_rs));
        chk({tag, ".step_err"},  W'(bus.step_err),  W'(e_se));
        chk({tag, ".alarm"},     W'(bus.alarm),     W'(m_alarm));
        chk({tag, ".err_run"},   W'(bus.err_run),   W'(m_err));
`ifdef MON_STAT_EN
        chk({tag, ".up_events"},   W'(bus.up_events),   W'(m_up));
        chk({tag, ".down_events"}, W'(bus.down_events), W'(m_down));
`else
        chk({tag, ".up_events"},   W'(bus.up_events),   '0);
        chk({tag, ".down_events"}, W'(bus.down_events), '0);
`endif
    endtask

    task automatic step(input string tag, input bit v, input bit c, input logic [W-1:0] x);
        @(negedge clk);
        bus.cnt_valid = v;
        bus.clear     = c;
        bus.cnt_in    = x;
        @(posedge clk);
        model_clock(v, c, x);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear before the next edge
    task automatic mid_reset(input string tag);
        @(negedge clk);
        bus.cnt_valid = 0;
        bus.clear     = 0;
        #1 reset = 1'b1;
        #1;
        model_reset();
        check_all(tag);
        #1 reset = 1'b0;
    endtask

    logic [W-1:0] ones;
    logic [W-1:0] rv;

    initial begin
        ones = '1;
        bus.cnt_in = '0;
        bus.cnt_valid = 0;
        bus.clear = 0;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Up run
        step("up_ref", 1, 0, W'(5));
        step("up_6",   1, 0, W'(6));
        step("up_7",   1, 0, W'(7));
        step("up_8",   1, 0, W'(8));
        step("up_idle", 0, 0, W'(9));
        mid_reset("rst1");

        // Down through zero and wrap
        step("dn_ref",   1, 0, W'(1));
        step("dn_0",     1, 0, W'(0));
        step("dn_ones",  1, 0, ones);
        step("dn_ones1", 1, 0, ones - 1);
        step("up_wrap0", 1, 0, ones);
        step("up_wrap1", 1, 0, W'(0));
        mid_reset("rst2");

        // Counter reset detection
        step("rd_ref", 1, 0, W'(100));
        step("rd_101", 1, 0, W'(101));
        step("rd_0",   1, 0, W'(0));
        step("rd_1",   1, 0, W'(1));

        // Alarm build-up, then legal step, then clear with a sample present
        mid_reset("rst3");
        step("al_ref", 1, 0, W'(10));
        step("al_20",  1, 0, W'(20));
        step("al_30",  1, 0, W'(30));
        step("al_40",  1, 0, W'(40));
        step("al_50",  1, 0, W'(50));
        step("al_51",  1, 0, W'(51));
        step("al_same", 1, 0, W'(51));
        step("clr_77", 1, 1, W'(77));
        step("clr_78", 1, 0, W'(78));
        step("clr_79", 1, 0, W'(79));

        // Back into alarm, then asynchronous reset
        step("ar_900", 1, 0, W'(900));
        step("ar_950", 1, 0, W'(950));
        step("ar_960", 1, 0, W'(960));
        step("ar_970", 1, 0, W'(970));
        mid_reset("ar_async");
        step("ar_ref", 1, 0, W'(3));
        step("ar_4",   1, 0, W'(4));

        // Randomised mix of legal, reset, illegal, idle and clear cycles
        for (int i = 0; i < 400; i++) begin
            int sel;
            bit v, c;
            sel = $urandom_range(0, 99);
            v   = ($urandom_range(0, 9) != 0);
            c   = ($urandom_range(0, 49) == 0);
            if (sel < 35)      rv = m_prev + 1;
            else if (sel < 65) rv = m_prev - 1;
            else if (sel < 72) rv = '0;
            else if (sel < 78) rv = m_prev;
            else if (sel < 82) rv = ones;
            else               rv = {$urandom, $urandom, $urandom, $urandom};
            step("rand", v, c, rv);
            if ($urandom_range(0, 199) == 0) mid_reset("rand_rst");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
